// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall encodings, sequencer
// states, exception codes and bus widths.
package pipeline_ctrl_pkg;

   localparam int REG_BUS   = 32;
   localparam int STALL_BUS = 6;
   localparam int PC_CNT_W  = 6;

   localparam logic [REG_BUS-1:0] PC_EXC_VECTOR = 32'h0000_0020;
   localparam logic [REG_BUS-1:0] PC_ERET_TYPE  = 32'h0000_000e;

   // bit order: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
   localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_BUS-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

endpackage

// File: rtl/pipeline_ctrl_mc_sequencer.sv
// Multi-cycle EX sequencer: holds the front of the pipe for a programmed
// number of cycles and pulses mc_done when the result may be written back.
//
// state   | meaning
// --------+----------------------------------------------------------
// MC_IDLE | no multi-cycle op; waiting for mc_start
// MC_BUSY | op in flight; cnt counts down the remaining busy cycles
// MC_DONE | final EX cycle; mc_done pulses, a new op may start here
module pipeline_ctrl_mc_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = PC_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mc_start,
   input  logic [CNT_W-1:0] mc_cycles,
   input  logic             abort_req,
   output logic             mc_busy,
   output logic             mc_done
);

   mc_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   mc_state_e        start_state;
   logic [CNT_W-1:0] start_cnt;

   // State and countdown registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MC_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, countdown and done pulse; an abort overrides everything.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      mc_done     = 1'b0;
      start_state = MC_DONE;
      start_cnt   = '0;
      // Ops of 0 or 1 cycles have no busy phase and finish on the next cycle.
      if (mc_cycles > CNT_W'(1)) begin
         start_state = MC_BUSY;
         start_cnt   = mc_cycles - CNT_W'(1);
      end
      case (state)
         MC_IDLE: begin
            if (mc_start) begin
               state_nxt = start_state;
               cnt_nxt   = start_cnt;
            end
         end
         MC_BUSY: begin
            // cnt holds the busy cycles left including this one.
            if (cnt <= CNT_W'(1)) begin
               state_nxt = MC_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         MC_DONE: begin
            mc_done   = 1'b1;
            state_nxt = MC_IDLE;
            cnt_nxt   = '0;
            if (mc_start) begin
               state_nxt = start_state;
               cnt_nxt   = start_cnt;
            end
         end
         default: begin
            state_nxt = MC_IDLE;
            cnt_nxt   = '0;
         end
      endcase
      if (abort_req) begin
         state_nxt = MC_IDLE;
         cnt_nxt   = '0;
         mc_done   = 1'b0;
      end
   end

   assign mc_busy = (state == MC_BUSY);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall vector priority, exception/ERET
// redirect and multi-cycle EX sequencing.
// Optional macro CTRL_PERF_CNT_EN adds a saturating stall-cycle counter.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [REG_BUS-1:0] EXC_VECTOR = PC_EXC_VECTOR,
   parameter int                 CNT_W      = PC_CNT_W,
   parameter logic [REG_BUS-1:0] ERET_TYPE  = PC_ERET_TYPE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stallreq_if,
   input  logic                 stallreq_id,
   input  logic                 stallreq_ex,
   input  logic                 stallreq_mem,
   input  logic                 mc_start,
   input  logic [CNT_W-1:0]     mc_cycles,
   input  logic [REG_BUS-1:0]   excepttype_i,
   input  logic [REG_BUS-1:0]   cp0_epc_i,
   output logic [STALL_BUS-1:0] stall,
   output logic                 flush,
   output logic [REG_BUS-1:0]   new_pc,
   output logic                 mc_busy,
   output logic                 mc_done
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cycles
`endif
);

   logic exc;

   assign exc = (excepttype_i != '0);

   pipeline_ctrl_mc_sequencer #(.CNT_W(CNT_W)) u_mc_seq (
      .clk       (clk),
      .rst       (rst),
      .mc_start  (mc_start),
      .mc_cycles (mc_cycles),
      .abort_req (exc),
      .mc_busy   (mc_busy),
      .mc_done   (mc_done)
   );

   // Stall priority and redirect; held at zero while reset is asserted so
   // the outputs drop without waiting for a clock.
   always_comb begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = '0;
      if (rst) begin
         if (exc) begin
            flush  = 1'b1;
            new_pc = (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
         end else if (stallreq_mem) begin
            stall = STALL_MEM;
         end else if (stallreq_ex || mc_busy) begin
            stall = STALL_EX;
         end else if (stallreq_id) begin
            stall = STALL_ID;
         end else if (stallreq_if) begin
            stall = STALL_IF;
         end
      end
   end

`ifdef CTRL_PERF_CNT_EN
   // Count PC-stalled cycles, saturating; a flush restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (flush) begin
         stall_cycles <= '0;
      end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Inputs change 1ns after each rising edge
// and outputs are checked 1ns later, well before the next edge.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic        mc_start;
   logic [5:0]  mc_cycles;
   logic [31:0] excepttype_i, cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_busy, mc_done;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   pipeline_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .mc_start     (mc_start),
      .mc_cycles    (mc_cycles),
      .excepttype_i (excepttype_i),
      .cp0_epc_i    (cp0_epc_i),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .mc_busy      (mc_busy),
      .mc_done      (mc_done)
`ifdef CTRL_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stallreq_if  = 1'b0;
      stallreq_id  = 1'b0;
      stallreq_ex  = 1'b0;
      stallreq_mem = 1'b0;
      mc_start     = 1'b0;
      mc_cycles    = 6'd0;
      excepttype_i = 32'h0;
      cp0_epc_i    = 32'h0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b0;
      step(); step();
      #1;
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL reset_stall got=%b exp=000000", stall); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
      rst = 1'b1;
      step();
      #1;
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL rel_stall got=%b exp=000000", stall); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rel_flush got=%b exp=0", flush); end
      checks++; if (new_pc !== 32'h0) begin failures++; $display("FAIL rel_new_pc got=%h exp=0", new_pc); end
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL rel_busy got=%b exp=0", mc_busy); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL rel_done got=%b exp=0", mc_done); end
   endtask

   task automatic test_priority();
      logic [3:0] req [5];
      logic [5:0] exp [5];
      req[0] = 4'b0100; exp[0] = 6'b000111; // id
      req[1] = 4'b0101; exp[1] = 6'b011111; // id + mem
      req[2] = 4'b1000; exp[2] = 6'b000011; // if
      req[3] = 4'b0010; exp[3] = 6'b001111; // ex
      req[4] = 4'b1110; exp[4] = 6'b001111; // if + id + ex
      for (int i = 0; i < 5; i++) begin
         step();
         {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = req[i];
         #1;
         checks++; if (stall !== exp[i]) begin failures++; $display("FAIL prio_%0d got=%b exp=%b", i, stall, exp[i]); end
         checks++; if (flush !== 1'b0) begin failures++; $display("FAIL prio_flush_%0d got=%b exp=0", i, flush); end
      end
      step();
      clear_inputs();
      #1;
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL prio_none got=%b exp=000000", stall); end
   endtask

   task automatic test_multicycle();
      step();
      mc_start = 1'b1; mc_cycles = 6'd4;
      #1;
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL mc4_T_busy got=%b exp=0", mc_busy); end
      for (int k = 1; k <= 3; k++) begin
         step();
         mc_start = 1'b0; mc_cycles = 6'd0;
         #1;
         checks++; if (mc_busy !== 1'b1) begin failures++; $display("FAIL mc4_busy_T%0d got=%b exp=1", k, mc_busy); end
         checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL mc4_stall_T%0d got=%b exp=001111", k, stall); end
         checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL mc4_done_T%0d got=%b exp=0", k, mc_done); end
      end
      step();
      #1;
      checks++; if (mc_done !== 1'b1) begin failures++; $display("FAIL mc4_done_T4 got=%b exp=1", mc_done); end
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL mc4_busy_T4 got=%b exp=0", mc_busy); end
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL mc4_stall_T4 got=%b exp=000000", stall); end
      step();
      #1;
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL mc4_done_T5 got=%b exp=0", mc_done); end
   endtask

   task automatic test_short_ops();
      for (int n = 0; n <= 1; n++) begin
         step();
         mc_start = 1'b1; mc_cycles = 6'(n);
         step();
         mc_start = 1'b0; mc_cycles = 6'd0;
         #1;
         checks++; if (mc_done !== 1'b1) begin failures++; $display("FAIL short%0d_done got=%b exp=1", n, mc_done); end
         checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL short%0d_busy got=%b exp=0", n, mc_busy); end
         step();
         #1;
         checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL short%0d_after got=%b exp=0", n, mc_done); end
      end
   endtask

   task automatic test_back_to_back();
      step();
      mc_start = 1'b1; mc_cycles = 6'd2;
      step();
      mc_start = 1'b0;
      #1;
      checks++; if (mc_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", mc_busy); end
      step();
      mc_start = 1'b1; mc_cycles = 6'd1;
      #1;
      checks++; if (mc_done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", mc_done); end
      step();
      mc_start = 1'b0; mc_cycles = 6'd0;
      #1;
      checks++; if (mc_done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", mc_done); end
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy2 got=%b exp=0", mc_busy); end
      step();
      #1;
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", mc_done); end
   endtask

   task automatic test_exc_busy();
      step();
      mc_start = 1'b1; mc_cycles = 6'd5;
      step();
      mc_start = 1'b0; mc_cycles = 6'd0;
      step();
      step();
      excepttype_i = 32'h1; stallreq_mem = 1'b1;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL excb_flush got=%b exp=1", flush); end
      checks++; if (new_pc !== 32'h0000_0020) begin failures++; $display("FAIL excb_new_pc got=%h exp=00000020", new_pc); end
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL excb_stall got=%b exp=000000", stall); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL excb_done got=%b exp=0", mc_done); end
      step();
      excepttype_i = 32'h0; stallreq_mem = 1'b0;
      #1;
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL excb_idle_busy got=%b exp=0", mc_busy); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL excb_idle_done got=%b exp=0", mc_done); end
      checks++; if (new_pc !== 32'h0) begin failures++; $display("FAIL excb_idle_pc got=%h exp=0", new_pc); end
      step();
      #1;
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL excb_late_done got=%b exp=0", mc_done); end
   endtask

   task automatic test_exc_done();
      step();
      mc_start = 1'b1; mc_cycles = 6'd1;
      step();
      mc_start = 1'b0; excepttype_i = 32'h4;
      #1;
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL excd_done got=%b exp=0", mc_done); end
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL excd_flush got=%b exp=1", flush); end
      step();
      excepttype_i = 32'h0;
      #1;
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL excd_after got=%b exp=0", mc_done); end
   endtask

   task automatic test_eret_start();
      step();
      excepttype_i = 32'h0000_000e; cp0_epc_i = 32'h8000_1234;
      mc_start = 1'b1; mc_cycles = 6'd3; stallreq_id = 1'b1;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL eret_flush got=%b exp=1", flush); end
      checks++; if (new_pc !== 32'h8000_1234) begin failures++; $display("FAIL eret_new_pc got=%h exp=80001234", new_pc); end
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL eret_stall got=%b exp=000000", stall); end
      step();
      clear_inputs();
      #1;
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL eret_busy1 got=%b exp=0", mc_busy); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL eret_done1 got=%b exp=0", mc_done); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL eret_flush1 got=%b exp=0", flush); end
      step();
      #1;
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL eret_busy2 got=%b exp=0", mc_busy); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL eret_done2 got=%b exp=0", mc_done); end
   endtask

   task automatic test_reset_busy();
      step();
      mc_start = 1'b1; mc_cycles = 6'd6;
      step();
      mc_start = 1'b0; mc_cycles = 6'd0;
      #1;
      checks++; if (mc_busy !== 1'b1) begin failures++; $display("FAIL rstb_pre_busy got=%b exp=1", mc_busy); end
      #1;
      rst = 1'b0;
      #1;
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL rstb_busy got=%b exp=0", mc_busy); end
      checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL rstb_stall got=%b exp=000000", stall); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL rstb_done got=%b exp=0", mc_done); end
      step();
      rst = 1'b1;
      step();
      #1;
      checks++; if (mc_busy !== 1'b0) begin failures++; $display("FAIL rstb_after got=%b exp=0", mc_busy); end
      checks++; if (mc_done !== 1'b0) begin failures++; $display("FAIL rstb_after_done got=%b exp=0", mc_done); end
   endtask

`ifdef CTRL_PERF_CNT_EN
   task automatic test_perf();
      step();
      stallreq_if = 1'b1;
      step(); step(); step();
      stallreq_if = 1'b0;
      #1;
      checks++; if (stall_cycles !== 32'd3) begin failures++; $display("FAIL perf_count got=%0d exp=3", stall_cycles); end
      excepttype_i = 32'h1;
      step();
      excepttype_i = 32'h0;
      #1;
      checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL perf_clear got=%0d exp=0", stall_cycles); end
   endtask
`endif

   initial begin
      test_reset();
      test_priority();
      test_multicycle();
      test_short_ops();
      test_back_to_back();
      test_exc_busy();
      test_exc_done();
      test_eret_start();
      test_reset_busy();
`ifdef CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline controller for the MIPS32 five-stage core.
- Generates the 6-bit stall vector and the flush/new_pc pair consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences multi-cycle EX operations (mult/div) by holding the front of the pipeline for a programmed cycle count.
- Redirects fetch on exceptions and ERET.

Parameters:
- EXC_VECTOR, 32'h0000_0020, fetch address for any non-ERET exception.
- CNT_W, 6, width of the multi-cycle countdown counter.
- ERET_TYPE, 32'h0000_000e, excepttype_i code meaning ERET.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_if  in  1  IF stall request (instruction bus busy).
- stallreq_id  in  1  ID stall request (load-use hazard).
- stallreq_ex  in  1  EX stall request (combinational, non-sequenced).
- stallreq_mem  in  1  MEM stall request (data bus busy).
- mc_start  in  1  EX begins a multi-cycle operation; 1-cycle pulse.
- mc_cycles  in  CNT_W  total EX cycles for that operation; sampled with mc_start.
- excepttype_i  in  32  exception type from MEM; 0 = none.
- cp0_epc_i  in  32  current EPC.
- stall  out  6  [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb.
- flush  out  1  flush all pipeline registers this cycle.
- new_pc  out  32  redirect target, valid when flush=1.
- mc_busy  out  1  multi-cycle operation in progress.
- mc_done  out  1  1-cycle pulse: EX may write back the multi-cycle result.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0. Outputs: stall=6'b000000, flush=0, new_pc=0, mc_busy=0, mc_done=0.
- FSM states: IDLE, BUSY, DONE. State and cnt are registered; all outputs are decoded combinationally from the state and the current inputs.
- IDLE → BUSY on mc_start=1 with excepttype_i==0. Load cnt = max(mc_cycles,1)−1.
- IDLE, mc_cycles of 0 or 1: go directly to DONE, skipping BUSY.
- BUSY: cnt decrements each cycle. At cnt==0 go to DONE. mc_start in BUSY is ignored.
- DONE: mc_done=1 for exactly one cycle, then IDLE. mc_start in DONE is honoured as if in IDLE (back-to-back ops).
- mc_busy = (state==BUSY).
- Stall vector, highest stage wins:
  - stallreq_mem → 011111
  - stallreq_ex or state==BUSY → 001111
  - stallreq_id → 000111
  - stallreq_if → 000011
  - otherwise → 000000
- In DONE, stall takes only the external-request value.
- Exception (excepttype_i≠0):
  - flush=1 and stall=000000 in the same cycle; flush overrides every stall request.
  - new_pc = cp0_epc_i if excepttype_i==ERET_TYPE, else EXC_VECTOR.
  - Next state = IDLE and cnt=0. A multi-cycle op in BUSY/DONE is aborted; mc_done is suppressed in that cycle.
  - Exception coincident with mc_start: the exception wins and no op starts.
- When flush=0, new_pc = 0.
- Latency:
  - An op started at cycle T with mc_cycles=N asserts mc_busy over T+1..T+N−1 and mc_done at T+N. For N≤1, mc_done is at T+1.
  - Front-of-pipe stall tracks mc_busy.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles (32): counts cycles with stall[0]=1 and flush=0.
  - Saturates at 32'hFFFF_FFFF.
  - Resets to 0 on rst.
  - Also clears synchronously on flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines:
  - Stall-vector constants (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM).
  - FSM state encodings.
  - ERET type code.
  - Default exception vector.
  - Widths (RegBus, StallBus).
- One natural sub-module: mc_sequencer, holding the FSM plus countdown and producing mc_busy/mc_done/abort. Stall priority and redirect logic stay in pipeline_ctrl.

Test Plan:
- Reset release, no requests → stall=000000, flush=0, new_pc=0, mc_busy=0, mc_done=0.
- Priority: stallreq_id=1 → 000111. Add stallreq_mem=1 → 011111. stallreq_if only → 000011.
- mc_start with mc_cycles=4 at T → mc_busy=1 and stall=001111 at T+1..T+3; mc_done=1 at T+4 only; stall=000000 at T+4.
- mc_cycles=0 and mc_cycles=1 → no BUSY cycle; mc_done pulse at T+1.
- excepttype_i=0x1 during BUSY (cnt=2) with stallreq_mem=1 → flush=1, new_pc=0x20, stall=000000; next cycle IDLE; no mc_done.
- excepttype_i=0xe, cp0_epc_i=0x8000_1234 coincident with mc_start → flush=1, new_pc=0x8000_1234, mc_busy stays 0.
- rst asserted in BUSY → outputs drop to reset values asynchronously, before the next clock edge.
